baser_block_sync: RTL and testbench

BASER_BLOCK_SYNC -- requirements
Module: baser_block_sync

---
 rtl/baser_block_sync_pkg.sv | 50 +++++
 rtl/baser_bit_aligner.sv | 22 ++
 rtl/baser_block_sync.sv | 182 ++++++++++++++++++
 tb/tb_baser_block_sync.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baser_block_sync_pkg.sv
// Shared BASE-R definitions for the 64b/66b receive path.
// Holds the block geometry, sync-header codes, block-type and XGMII
// characters used by the block checker, the idle control block that the
// synchroniser emits while it is not delivering data, and the state
// encoding of the block-lock machine.
//
// Bit-order note: blocks are stored with the first received bit in [0], so
// the sync header sits in [1:0]. A control header (first bit 1, second bit 0)
// therefore reads as 2'b01 and a data header as 2'b10.
package baser_block_sync_pkg;

  localparam int DATA_WIDTH  = 64;
  localparam int HDR_WIDTH   = 2;
  localparam int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH;
  localparam int OFFSET_W    = 7;

  // Sync-header codes as they appear in [1:0]
  localparam logic [1:0] SH_CTRL = 2'b01;
  localparam logic [1:0] SH_DATA = 2'b10;

  // BASE-R block type field values (bits [9:2] of a control block)
  localparam logic [7:0] BT_IDLE   = 8'h1E;
  localparam logic [7:0] BT_START0 = 8'h78;
  localparam logic [7:0] BT_TERM0  = 8'h87;
  localparam logic [7:0] BT_ORDSET = 8'h4B;

  // XGMII control characters shared with the checker
  localparam logic [7:0] MII_IDLE  = 8'h07;
  localparam logic [7:0] MII_START = 8'hFB;
  localparam logic [7:0] MII_TERM  = 8'hFD;
  localparam logic [7:0] MII_ERROR = 8'hFE;
  localparam logic [7:0] MII_SEQ   = 8'h9C;

  // Idle control block: control header, type 0x1E, eight 7-bit idle
  // codes that are all zero.
  localparam logic [FRAME_WIDTH-1:0] IDLE_BLOCK = {56'd0, BT_IDLE, SH_CTRL};

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_SLIP   = 2'd2,
    ST_LOCKED = 2'd3
  } sync_state_e;

  // A header is legal only when its two bits differ.
  function automatic logic sh_valid(input logic [1:0] hdr);
    return (hdr == SH_CTRL) || (hdr == SH_DATA);
  endfunction

endpackage

// File: rtl/baser_bit_aligner.sv
// Combinational barrel select that extracts one 66b candidate block from a
// two-word window of the serial stream.
//
// Ports:
//   window_i  [2*FRAME_WIDTH-1:0]  {newest word, previous word}; bit 0 earliest
//   offset_i  [OFFSET_W-1:0]       start bit of the candidate, 0..FRAME_WIDTH-1
//   block_o   [FRAME_WIDTH-1:0]    candidate block, header in [1:0]
module baser_bit_aligner
  import baser_block_sync_pkg::*;
#(
  parameter int FRAME_WIDTH = baser_block_sync_pkg::FRAME_WIDTH,
  parameter int OFFSET_W    = baser_block_sync_pkg::OFFSET_W
) (
  input  logic [2*FRAME_WIDTH-1:0] window_i,
  input  logic [OFFSET_W-1:0]      offset_i,
  output logic [FRAME_WIDTH-1:0]   block_o
);

  // offset_i never exceeds FRAME_WIDTH-1, so the slice stays inside the window.
  assign block_o = window_i[offset_i +: FRAME_WIDTH];

endmodule

// File: rtl/baser_block_sync.sv
// BASE-R 66b block synchroniser.
// Searches the unaligned receive stream for the sync-header boundary by
// slipping one bit at a time, declares block lock after SH_CNT_MAX
// consecutive legal headers and drops lock when SH_INVLD_MAX illegal headers
// fall inside one SH_CNT_MAX-header window. Aligned blocks tested while
// locked are forwarded one cycle after the input word; all other tested
// words produce the idle control block with o_valid low.
//
// Ports:
//   clk                 rising-edge clock
//   i_rst_n             asynchronous active-low reset
//   i_valid             qualifies i_raw; when low everything holds
//   i_raw               unaligned word in serial order, bit 0 earliest
//   o_rx_coded          aligned block (header in [1:0]) or idle block
//   o_valid             o_rx_coded is a block tested while locked
//   o_block_lock        block lock indication
//   o_offset            current alignment offset, 0..FRAME_WIDTH-1
//   o_slip_count        total slips, wraps mod 2^32
//   o_lock_loss_count   total lock-to-unlock transitions, wraps mod 2^32
module baser_block_sync #(
  parameter int FRAME_WIDTH  = baser_block_sync_pkg::FRAME_WIDTH,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [FRAME_WIDTH-1:0] i_raw,
  output logic [FRAME_WIDTH-1:0] o_rx_coded,
  output logic                   o_valid,
  output logic                   o_block_lock,
  output logic [6:0]             o_offset,
  output logic [31:0]            o_slip_count,
  output logic [31:0]            o_lock_loss_count
);

  import baser_block_sync_pkg::*;

  localparam int CNT_W = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W = $clog2(SH_INVLD_MAX + 1);

  localparam logic [FRAME_WIDTH-1:0] IDLE_W    = FRAME_WIDTH'(IDLE_BLOCK);
  localparam logic [6:0]             OFF_LAST  = 7'(FRAME_WIDTH - 1);
  localparam logic [CNT_W-1:0]       CNT_LIMIT = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]       INV_LIMIT = INV_W'(SH_INVLD_MAX);

  sync_state_e            state_q, state_d;
  logic [6:0]             offset_q, offset_d;
  logic [FRAME_WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]       sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]       sh_invld_q, sh_invld_d;
  logic                   valid_q, valid_d;
  logic                   lock_q, lock_d;
  logic [31:0]            slip_cnt_q, slip_cnt_d;
  logic [31:0]            loss_cnt_q, loss_cnt_d;
  logic [FRAME_WIDTH-1:0] rx_coded_q, rx_coded_d;

  logic [FRAME_WIDTH-1:0] cand;
  logic                   hdr_ok;
  logic [CNT_W-1:0]       sh_cnt_inc;
  logic [INV_W-1:0]       sh_invld_inc;
  logic                   slip_req;

  // The previous word supplies the earlier bits, the new word the later ones.
  baser_bit_aligner #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .OFFSET_W    (7)
  ) u_aligner (
    .window_i (/* newest word on top */ {i_raw, prev_q}),
    .offset_i (offset_q),
    .block_o  (cand)
  );

  assign hdr_ok       = sh_valid(cand[1:0]);
  assign sh_cnt_inc   = sh_cnt_q + CNT_W'(1);
  assign sh_invld_inc = sh_invld_q + INV_W'(1);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_INIT;
      offset_q   <= '0;
      prev_q     <= '0;
      sh_cnt_q   <= '0;
      sh_invld_q <= '0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
      slip_cnt_q <= '0;
      loss_cnt_q <= '0;
      rx_coded_q <= IDLE_W;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      prev_q     <= prev_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_invld_q <= sh_invld_d;
      valid_q    <= valid_d;
      lock_q     <= lock_d;
      slip_cnt_q <= slip_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      rx_coded_q <= rx_coded_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    prev_d     = prev_q;
    sh_cnt_d   = sh_cnt_q;
    sh_invld_d = sh_invld_q;
    valid_d    = 1'b0;
    lock_d     = lock_q;
    slip_cnt_d = slip_cnt_q;
    loss_cnt_d = loss_cnt_q;
    rx_coded_d = rx_coded_q;
    slip_req   = 1'b0;

    // An idle input cycle freezes all state; only o_valid drops.
    if (i_valid) begin
      prev_d     = i_raw;
      rx_coded_d = IDLE_W;

      case (state_q)
        // INIT only primes prev; SLIP throws one word away so the window
        // is refilled at the new offset before testing resumes.
        ST_INIT, ST_SLIP: state_d = ST_HUNT;

        ST_HUNT: begin
          if (!hdr_ok) begin
            slip_req = 1'b1;
          end else if (sh_cnt_inc == CNT_LIMIT) begin
            state_d    = ST_LOCKED;
            sh_cnt_d   = '0;
            sh_invld_d = '0;
            lock_d     = 1'b1;
          end else begin
            sh_cnt_d = sh_cnt_inc;
          end
        end

        ST_LOCKED: begin
          // Lock loss is checked first so it wins over a coinciding
          // window end.
          if (!hdr_ok && (sh_invld_inc == INV_LIMIT)) begin
            slip_req   = 1'b1;
            lock_d     = 1'b0;
            loss_cnt_d = loss_cnt_q + 32'd1;
          end else begin
            valid_d    = 1'b1;
            rx_coded_d = cand;
            if (sh_cnt_inc == CNT_LIMIT) begin
              sh_cnt_d   = '0;
              sh_invld_d = '0;
            end else begin
              sh_cnt_d = sh_cnt_inc;
              if (!hdr_ok) begin
                sh_invld_d = sh_invld_inc;
              end
            end
          end
        end

        default: state_d = ST_INIT;
      endcase

      if (slip_req) begin
        state_d    = ST_SLIP;
        offset_d   = (offset_q == OFF_LAST) ? 7'd0 : offset_q + 7'd1;
        slip_cnt_d = slip_cnt_q + 32'd1;
        sh_cnt_d   = '0;
        sh_invld_d = '0;
      end
    end
  end

  assign o_rx_coded        = rx_coded_q;
  assign o_valid           = valid_q;
  assign o_block_lock      = lock_q;
  assign o_offset          = offset_q;
  assign o_slip_count      = slip_cnt_q;
  assign o_lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_baser_block_sync.sv
// Bench for baser_block_sync: a scenario table with expected end states,
// hand-written multi-cycle sequences and randomized streams, all checked
// cycle by cycle against a serial-stream reference model.
module tb_baser_block_sync;

  localparam int FW      = 66;
  localparam int CNT_MAX = 64;
  localparam int INV_MAX = 16;
  localparam logic [65:0] IDLE = {56'd0, 8'h1E, 2'b01};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vld = 1'b0;
  logic [65:0] raw = '0;
  logic [65:0] o_rx_coded;
  logic        o_valid;
  logic        o_block_lock;
  logic [6:0]  o_offset;
  logic [31:0] o_slip_count;
  logic [31:0] o_lock_loss_count;

  always #5 clk = ~clk;

  baser_block_sync #(
    .FRAME_WIDTH  (FW),
    .SH_CNT_MAX   (CNT_MAX),
    .SH_INVLD_MAX (INV_MAX)
  ) dut (
    .clk               (clk),
    .i_rst_n           (rst_n),
    .i_valid           (vld),
    .i_raw             (raw),
    .o_rx_coded        (o_rx_coded),
    .o_valid           (o_valid),
    .o_block_lock      (o_block_lock),
    .o_offset          (o_offset),
    .o_slip_count      (o_slip_count),
    .o_lock_loss_count (o_lock_loss_count)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus stream: serial bits still to send, and the blocks they encode.
  bit          bq[$];
  logic [65:0] blocks[$];
  int          bound;

  // Reference model. Mode: 0 first word, 1 hunting, 2 discarding, 3 locked.
  int          m_mode, m_off, m_cnt, m_inv;
  bit          m_valid, m_lock;
  logic [31:0] m_slips, m_losses;
  logic [65:0] m_rx;
  logic [65:0] hist[$];
  bit          have_blk;
  logic [65:0] exp_blk;

  task automatic chk(string name, logic [65:0] act, logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_off = 0; m_cnt = 0; m_inv = 0;
    m_valid = 0; m_lock = 0; m_slips = 0; m_losses = 0;
    m_rx = IDLE; have_blk = 0;
    hist.delete();
  endtask

  // Candidate block starting at absolute serial bit 'pos' since reset.
  function automatic logic [65:0] cand_at(int pos);
    logic [65:0] c, t;
    for (int i = 0; i < FW; i++) begin
      t = hist[(pos + i) / FW];
      c[i] = t[(pos + i) % FW];
    end
    return c;
  endfunction

  task automatic model_slip();
    m_off = (m_off + 1) % FW;
    m_slips = m_slips + 32'd1;
    m_cnt = 0; m_inv = 0;
    m_mode = 2;
  endtask

  task automatic model_step(bit v, logic [65:0] w);
    int k, pos;
    logic [65:0] c;
    bit ok;
    have_blk = 0;
    if (!v) begin
      m_valid = 0;
      return;
    end
    hist.push_back(w);
    k = hist.size() - 1;
    m_valid = 0;
    m_rx = IDLE;
    if (m_mode == 0 || m_mode == 2) begin
      m_mode = 1;
      return;
    end
    pos = FW * (k - 1) + m_off;
    c = cand_at(pos);
    ok = (c[1:0] == 2'b01) || (c[1:0] == 2'b10);
    if (m_mode == 1) begin
      if (!ok) model_slip();
      else begin
        m_cnt++;
        if (m_cnt == CNT_MAX) begin
          m_mode = 3; m_cnt = 0; m_inv = 0; m_lock = 1;
        end
      end
    end else begin
      m_cnt++;
      if (!ok) m_inv++;
      if (m_inv == INV_MAX) begin
        model_slip();
        m_losses = m_losses + 32'd1;
        m_lock = 0;
      end else begin
        if (m_cnt == CNT_MAX) begin
          m_cnt = 0; m_inv = 0;
        end
        m_valid = 1;
        m_rx = c;
        if (pos >= bound && (pos - bound) % FW == 0 && (pos - bound) / FW < blocks.size()) begin
          have_blk = 1;
          exp_blk = blocks[(pos - bound) / FW];
        end
      end
    end
  endtask

  task automatic compare_outputs(string tag);
    chk({tag, "_valid"},  66'(o_valid),           66'(m_valid));
    chk({tag, "_lock"},   66'(o_block_lock),      66'(m_lock));
    chk({tag, "_offset"}, 66'(o_offset),          66'(m_off));
    chk({tag, "_slips"},  66'(o_slip_count),      66'(m_slips));
    chk({tag, "_losses"}, 66'(o_lock_loss_count), 66'(m_losses));
    chk({tag, "_rx"},     o_rx_coded,             m_rx);
    if (have_blk) chk({tag, "_orig_block"}, o_rx_coded, exp_blk);
  endtask

  task automatic gen_block(bit bad);
    logic [65:0] blk;
    logic [1:0]  hdr;
    hdr = bad ? 2'b00 : ($urandom_range(0, 1) != 0 ? 2'b01 : 2'b10);
    blk = {$urandom, $urandom, hdr};
    for (int i = 0; i < FW; i++) bq.push_back(blk[i]);
    blocks.push_back(blk);
  endtask

  task automatic start_stream(int b);
    bq.delete();
    blocks.delete();
    bound = b;
    for (int i = 0; i < b; i++) bq.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic apply(bit v, logic [65:0] w);
    @(negedge clk);
    vld = v;
    raw = w;
    @(posedge clk);
    model_step(v, w);
    #1;
    compare_outputs("cyc");
  endtask

  task automatic drive(bit v, int bad_pct);
    logic [65:0] w;
    if (v) begin
      while (bq.size() < FW) gen_block(int'($urandom_range(0, 99)) < bad_pct);
      for (int i = 0; i < FW; i++) w[i] = bq.pop_front();
    end else begin
      w = {2'($urandom), $urandom, $urandom};
    end
    apply(v, w);
  endtask

  task automatic send_blocks(int from, int to, int lo, int hi);
    for (int j = from; j <= to; j++) begin
      gen_block(j >= lo && j <= hi);
      drive(1'b1, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld = 1'b0;
    model_reset();
    #1;
    compare_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge.
  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    vld = 1'b0;
    model_reset();
    #1;
    compare_outputs("arst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int bound;
    bit toggle;
    int nwords;
    bit exp_lock;
    int exp_off;
    int exp_slips;
  } scen_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    scen_t       tab[5];
    logic [65:0] w, p;
    logic [31:0] sb;

    tab[0] = '{0,  1'b0, 64,  1'b0, 0,  0};
    tab[1] = '{0,  1'b0, 65,  1'b1, 0,  0};
    tab[2] = '{23, 1'b0, 400, 1'b1, 23, 23};
    tab[3] = '{0,  1'b1, 65,  1'b1, 0,  0};
    tab[4] = '{40, 1'b1, 500, 1'b1, 40, 40};

    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    compare_outputs("por");
    #10;
    rst_n = 1'b1;

    // Scenario table: lock acquisition at several boundaries and valid rates
    for (int s = 0; s < 5; s++) begin
      do_reset();
      start_stream(tab[s].bound);
      for (int n = 0; n < tab[s].nwords; n++) begin
        drive(1'b1, 0);
        if (tab[s].toggle) drive(1'b0, 0);
      end
      chk($sformatf("scen%0d_lock", s),   66'(o_block_lock), 66'(tab[s].exp_lock));
      chk($sformatf("scen%0d_offset", s), 66'(o_offset),     66'(tab[s].exp_off));
      chk($sformatf("scen%0d_slips", s),  66'(o_slip_count), 66'(tab[s].exp_slips));
    end

    // 15 bad headers in a window keep lock; 16 in the next window lose it
    do_reset();
    start_stream(0);
    for (int n = 0; n < 65; n++) drive(1'b1, 0);
    send_blocks(65, 71, 70, 84);
    chk("bad_hdr_valid", 66'(o_valid), 66'(1));
    chk("bad_hdr_pass",  66'(o_rx_coded[1:0]), 66'(0));
    send_blocks(72, 128, 70, 84);
    chk("win15_lock",   66'(o_block_lock),      66'(1));
    chk("win15_losses", 66'(o_lock_loss_count), 66'(0));
    send_blocks(129, 145, 129, 144);
    chk("win16_lock",   66'(o_block_lock),      66'(0));
    chk("win16_losses", 66'(o_lock_loss_count), 66'(1));
    chk("win16_offset", 66'(o_offset),          66'(1));
    chk("win16_slips",  66'(o_slip_count),      66'(1));

    // 16th bad header is also the last header of the window
    do_reset();
    start_stream(0);
    for (int n = 0; n < 65; n++) drive(1'b1, 0);
    send_blocks(65, 128, 112, 127);
    chk("coinc_lock",   66'(o_block_lock),      66'(0));
    chk("coinc_losses", 66'(o_lock_loss_count), 66'(1));
    chk("coinc_offset", 66'(o_offset),          66'(1));

    // Offset wrap from 65 back to 0
    do_reset();
    start_stream(0);
    for (int i = 0; i < 4000 && !(m_mode == 1 && m_off == 65); i++) drive(1'b1, 50);
    chk("wrap_at_65", 66'(o_offset), 66'(65));
    sb = m_slips;
    p = hist[hist.size() - 1];
    w = {2'($urandom), $urandom, $urandom};
    w[0] = p[65];
    apply(1'b1, w);
    chk("wrap_offset", 66'(o_offset),     66'(0));
    chk("wrap_slips",  66'(o_slip_count), 66'(sb + 32'd1));

    // Asynchronous reset mid-hunt and while locked
    do_reset();
    start_stream(0);
    for (int n = 0; n < 10; n++) drive(1'b1, 50);
    async_reset_check();
    start_stream(0);
    for (int n = 0; n < 65; n++) drive(1'b1, 0);
    chk("pre_arst_lock", 66'(o_block_lock), 66'(1));
    async_reset_check();
    start_stream(5);
    for (int n = 0; n < 300; n++) drive(1'b1, 0);
    chk("relock_offset", 66'(o_offset), 66'(5));

    // Randomized streams: random boundary, valid gaps and header errors
    for (int r = 0; r < 3; r++) begin
      do_reset();
      start_stream(int'($urandom_range(0, 65)));
      for (int n = 0; n < 1500; n++)
        drive(int'($urandom_range(0, 99)) < 80, (r == 2) ? 20 : r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
